// File: rtl/lpif_rx_x2_deskew.sv
// -----------------------------------------------------------------------------
// lpif_rx_x2_deskew
// Two-channel RX lane deskew. The block measures the skew between the channel
// marker bits (bit 39) and delays the leading channel so that both outputs
// present marker-aligned words. It re-acquires alignment when lock is lost.
//
// Optional build macro: LPIF_DESKEW_STROBE_CHECK_EN
//   When defined, the strobe bits (bit 1) are also compared while LOCKED.
//   A strobe mismatch counts as a marker mismatch.
// -----------------------------------------------------------------------------
module lpif_rx_x2_deskew #(
  parameter  int MAX_SKEW    = 3,
  parameter  int LOSS_THRESH = 4,
  parameter  int ERR_CNT_W   = 8,
  localparam int SKEW_W      = $clog2(MAX_SKEW + 1)
) (
  input  logic                 clk_rd,
  input  logic                 rst_rd,
  input  logic                 rx_online,
  input  logic [39:0]          rx_phy0_in,
  input  logic [39:0]          rx_phy1_in,
  output logic [39:0]          rx_phy0_out,
  output logic [39:0]          rx_phy1_out,
  output logic                 rx_deskew_locked,
  output logic                 rx_deskew_lead,
  output logic [SKEW_W-1:0]    rx_deskew_amt,
  output logic                 rx_deskew_err,
  output logic [ERR_CNT_W-1:0] rx_deskew_err_cnt
);

  localparam int MIS_W = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [SKEW_W-1:0]     amt_r, amt_nxt_s;
  logic [SKEW_W-1:0]     cnt_r, cnt_nxt_s;
  logic [SKEW_W:0]       cnt_inc_s;
  logic                  lead_r, lead_nxt_s;
  logic [MIS_W-1:0]      mis_r, mis_nxt_s, mis_inc_s;
  logic                  err_s;
  logic                  err_r;
  logic                  locked_r;
  logic [ERR_CNT_W-1:0]  err_cnt_r;

  // Stages 0..MAX_SKEW-1 live here; the output register acts as the final
  // selected stage, so stage d is reached with a total latency of 1 + d.
  logic [39:0]           dly0_r [MAX_SKEW];
  logic [39:0]           dly1_r [MAX_SKEW];
  logic [39:0]           out0_r, out1_r;
  logic [39:0]           out0_nxt_s, out1_nxt_s;
  logic [SKEW_W-1:0]     sel0_s, sel1_s;

  logic                  in_m0_s, in_m1_s, lag_m_s;
  logic                  om0_s, om1_s;
  logic                  strb_ne_s;
  logic                  mis_ev_s, mis_clr_s;

  assign in_m0_s   = rx_phy0_in[39];
  assign in_m1_s   = rx_phy1_in[39];
  assign lag_m_s   = lead_r ? in_m0_s : in_m1_s;
  assign cnt_inc_s = {1'b0, cnt_r} + (SKEW_W + 1)'(1'b1);
  assign mis_inc_s = mis_r + MIS_W'(1'b1);

  assign om0_s = out0_r[39];
  assign om1_s = out1_r[39];

`ifdef LPIF_DESKEW_STROBE_CHECK_EN
  assign strb_ne_s = out0_r[1] ^ out1_r[1];
`else
  assign strb_ne_s = 1'b0;
`endif

  assign mis_ev_s  = (om0_s ^ om1_s) | strb_ne_s;
  assign mis_clr_s = om0_s & om1_s & ~strb_ne_s;

  // Per-channel delay lines: stage 0 captures the raw input.
  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      for (int i = 0; i < MAX_SKEW; i++) begin
        dly0_r[i] <= 40'd0;
        dly1_r[i] <= 40'd0;
      end
    end else begin
      dly0_r[0] <= rx_phy0_in;
      dly1_r[0] <= rx_phy1_in;
      for (int i = 1; i < MAX_SKEW; i++) begin
        dly0_r[i] <= dly0_r[i-1];
        dly1_r[i] <= dly1_r[i-1];
      end
    end
  end

  // Output stage select; uses the next-cycle delay so a new amount applies
  // to the same edge that publishes it on rx_deskew_amt.
  always_comb begin
    sel0_s     = lead_nxt_s ? {SKEW_W{1'b0}} : amt_nxt_s;
    sel1_s     = lead_nxt_s ? amt_nxt_s : {SKEW_W{1'b0}};
    out0_nxt_s = rx_phy0_in;
    out1_nxt_s = rx_phy1_in;
    for (int i = 1; i <= MAX_SKEW; i++) begin
      out0_nxt_s = (sel0_s == SKEW_W'(i)) ? dly0_r[i-1] : out0_nxt_s;
      out1_nxt_s = (sel1_s == SKEW_W'(i)) ? dly1_r[i-1] : out1_nxt_s;
    end
  end

  // Acquisition / tracking state machine: next state and control updates.
  always_comb begin
    state_nxt_s = state_r;
    amt_nxt_s   = amt_r;
    lead_nxt_s  = lead_r;
    cnt_nxt_s   = cnt_r;
    mis_nxt_s   = mis_r;
    err_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        amt_nxt_s  = {SKEW_W{1'b0}};
        lead_nxt_s = 1'b0;
        cnt_nxt_s  = {SKEW_W{1'b0}};
        mis_nxt_s  = {MIS_W{1'b0}};
        if (rx_online) begin
          state_nxt_s = ST_SEARCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_SEARCH: begin
        mis_nxt_s = {MIS_W{1'b0}};
        cnt_nxt_s = {SKEW_W{1'b0}};
        if (in_m0_s && in_m1_s) begin
          amt_nxt_s   = {SKEW_W{1'b0}};
          lead_nxt_s  = 1'b0;
          state_nxt_s = ST_LOCKED;
        end else if (in_m1_s) begin
          lead_nxt_s  = 1'b1;
          state_nxt_s = ST_MEASURE;
        end else if (in_m0_s) begin
          lead_nxt_s  = 1'b0;
          state_nxt_s = ST_MEASURE;
        end else begin
          state_nxt_s = ST_SEARCH;
        end
      end

      ST_MEASURE: begin
        // Only the lagging channel matters here; a repeated leading marker
        // is ignored, and a simultaneous pair is treated as the lag arrival.
        if (cnt_inc_s > (SKEW_W + 1)'(MAX_SKEW)) begin
          err_s       = 1'b1;
          lead_nxt_s  = 1'b0;
          cnt_nxt_s   = {SKEW_W{1'b0}};
          state_nxt_s = ST_SEARCH;
        end else if (lag_m_s) begin
          amt_nxt_s   = cnt_inc_s[SKEW_W-1:0];
          mis_nxt_s   = {MIS_W{1'b0}};
          state_nxt_s = ST_LOCKED;
        end else begin
          cnt_nxt_s   = cnt_inc_s[SKEW_W-1:0];
        end
      end

      ST_LOCKED: begin
        if (mis_ev_s) begin
          if (mis_inc_s >= MIS_W'(LOSS_THRESH)) begin
            err_s       = 1'b1;
            amt_nxt_s   = {SKEW_W{1'b0}};
            lead_nxt_s  = 1'b0;
            mis_nxt_s   = {MIS_W{1'b0}};
            state_nxt_s = ST_SEARCH;
          end else begin
            mis_nxt_s   = mis_inc_s;
          end
        end else if (mis_clr_s) begin
          mis_nxt_s = {MIS_W{1'b0}};
        end else begin
          mis_nxt_s = mis_r;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Going offline wins over any in-state decision and never flags an error.
    if (!rx_online) begin
      state_nxt_s = ST_IDLE;
      amt_nxt_s   = {SKEW_W{1'b0}};
      lead_nxt_s  = 1'b0;
      cnt_nxt_s   = {SKEW_W{1'b0}};
      mis_nxt_s   = {MIS_W{1'b0}};
      err_s       = 1'b0;
    end else begin
      err_s       = err_s;
    end
  end

  // State, control and registered outputs.
  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      state_r   <= ST_IDLE;
      amt_r     <= {SKEW_W{1'b0}};
      lead_r    <= 1'b0;
      cnt_r     <= {SKEW_W{1'b0}};
      mis_r     <= {MIS_W{1'b0}};
      err_r     <= 1'b0;
      locked_r  <= 1'b0;
      err_cnt_r <= {ERR_CNT_W{1'b0}};
      out0_r    <= 40'd0;
      out1_r    <= 40'd0;
    end else begin
      state_r  <= state_nxt_s;
      amt_r    <= amt_nxt_s;
      lead_r   <= lead_nxt_s;
      cnt_r    <= cnt_nxt_s;
      mis_r    <= mis_nxt_s;
      err_r    <= err_s;
      locked_r <= (state_nxt_s == ST_LOCKED);
      out0_r   <= out0_nxt_s;
      out1_r   <= out1_nxt_s;
      if (err_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + ERR_CNT_W'(1'b1);
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign rx_phy0_out       = out0_r;
  assign rx_phy1_out       = out1_r;
  assign rx_deskew_locked  = locked_r;
  assign rx_deskew_lead    = lead_r;
  assign rx_deskew_amt     = amt_r;
  assign rx_deskew_err     = err_r;
  assign rx_deskew_err_cnt = err_cnt_r;

endmodule
